// File: rtl/sample_pkg.sv
// rtl/sample_pkg.sv - shared defaults and types for the I2S sample transmitter
package sample_pkg;

    localparam int IW_DEF        = 19;
    localparam int SLOT_DEF      = 24;
    localparam int DIV_DEF       = 4;
    localparam int FRAME_LEN_DEF = 2 * SLOT_DEF;

    typedef enum logic {
        WS_LEFT  = 1'b0,
        WS_RIGHT = 1'b1
    } ws_e;

    function automatic int frame_len(input int slot);
        return 2 * slot;
    endfunction

endpackage

// File: rtl/sample_i2s_tx_if.sv
// rtl/sample_i2s_tx_if.sv - sample source bundle feeding the I2S transmitter
interface sample_i2s_tx_if
    import sample_pkg::*;
#(
    parameter int IW = IW_DEF
);

    logic                 i_valid;
    logic signed [IW-1:0] i_data;
    logic                 i_clear;

    modport master (
        output i_valid,
        output i_data,
        output i_clear
    );

    modport slave (
        input i_valid,
        input i_data,
        input i_clear
    );

endinterface

// File: rtl/sck_gen.sv
// rtl/sck_gen.sv - bit clock divider with a one-cycle strobe on each falling sck
module sck_gen
    import sample_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic clk,
    input  logic i_reset_n,
    output logic o_sck,
    output logic o_shift
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap    = (cnt == CNT_LAST);
    // Strobe is high in the cycle whose closing edge drives sck 1->0.
    assign o_shift = wrap & o_sck;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt   <= '0;
            o_sck <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            o_sck <= ~o_sck;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sample_i2s_tx.sv
// rtl/sample_i2s_tx.sv - single-sample buffered I2S transmitter with overrun/underrun flags
module sample_i2s_tx
    import sample_pkg::*;
#(
    parameter int IW       = IW_DEF,
    parameter int SLOT     = SLOT_DEF,
    parameter int DIV      = DIV_DEF,
    parameter int MONO_DUP = 1
) (
    input  logic             clk,
    input  logic             i_reset_n,
    sample_i2s_tx_if.slave   s_in,
    output logic             o_sck,
    output logic             o_ws,
    output logic             o_sd,
    output logic             o_overrun,
    output logic             o_underrun
);

    localparam int            FRAME     = frame_len(SLOT);
    localparam int            XW        = $clog2(FRAME);
    localparam int            PAD       = SLOT - IW;
    localparam logic [XW-1:0] IDX_LAST  = XW'(FRAME - 1);
    localparam logic [XW-1:0] IDX_RIGHT = XW'(SLOT);

    logic             shift;
    logic             frame_start;
    logic [XW-1:0]    idx;
    logic [XW-1:0]    idx_nxt;
    logic [IW-1:0]    hold;
    logic             full;
    logic [FRAME-1:0] shreg;
    logic [SLOT-1:0]  word_l;
    logic [SLOT-1:0]  word_r;
    logic             set_over;
    logic             set_under;

    sck_gen #(
        .DIV (DIV)
    ) u_sck_gen (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .o_sck     (o_sck),
        .o_shift   (shift)
    );

    assign idx_nxt     = (idx == IDX_LAST) ? '0 : idx + XW'(1);
    assign frame_start = shift && (idx == IDX_LAST);

    // Left-justified: sample occupies the top IW bits, padding stays zero.
    assign word_l = {hold, {PAD{1'b0}}};
    assign word_r = (MONO_DUP != 0) ? word_l : '0;

    // A write landing on the frame-start transfer refills an emptied buffer.
    assign set_under = frame_start && !full;
    assign set_over  = s_in.i_valid && full && !frame_start;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idx   <= IDX_LAST;
            o_ws  <= WS_LEFT;
            o_sd  <= 1'b0;
            shreg <= '0;
        end else if (shift) begin
            idx  <= idx_nxt;
            o_ws <= (idx_nxt >= IDX_RIGHT) ? WS_RIGHT : WS_LEFT;
            if (frame_start) begin
                shreg <= full ? {word_l, word_r} : '0;
                o_sd  <= 1'b0;
            end else begin
                shreg <= {shreg[FRAME-2:0], 1'b0};
                o_sd  <= shreg[FRAME-1];
            end
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold <= '0;
            full <= 1'b0;
        end else if (s_in.i_valid) begin
            hold <= s_in.i_data;
            full <= 1'b1;
        end else if (frame_start) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_overrun  <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_overrun  <= set_over  | (o_overrun  & ~s_in.i_clear);
            o_underrun <= set_under | (o_underrun & ~s_in.i_clear);
        end
    end

endmodule
